// File: rtl/controller_pkg.sv
// controller_pkg: shared definitions for the serial game-controller poller.
//   - FSM state encodings and the state enum built from them
//   - Button bit positions inside a stored pad byte (pressed = 1)
//   - Number of divider ticks the pad latch is held high
package controller_pkg;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_LATCH_ENC    = 3'd1;
    localparam logic [2:0] ST_CLK_LOW_ENC  = 3'd2;
    localparam logic [2:0] ST_CLK_HIGH_ENC = 3'd3;
    localparam logic [2:0] ST_COMMIT_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_LATCH    = ST_LATCH_ENC,
        ST_CLK_LOW  = ST_CLK_LOW_ENC,
        ST_CLK_HIGH = ST_CLK_HIGH_ENC,
        ST_COMMIT   = ST_COMMIT_ENC
    } state_t;

    // Serial order of an NES pad: first bit shifted out lands in bit 0.
    typedef enum int unsigned {
        BTN_A      = 0,
        BTN_B      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7
    } btn_e;

    localparam int unsigned LATCH_TICKS = 2;

endpackage

// File: rtl/controller_poller_if.sv
// controller_poller_if: CPU-side bus of the controller poller.
//   cpu_address[1:0]  low CPU address bits (bit0 selects pad, bit1 selects edge mask when enabled)
//   SELECT_controller decoded controller address region
//   write_enable      CPU write strobe, active-high
//   data_out[7:0]     read data toward the CPU bus
//   data_oe           data_out valid / tri-state enable
interface controller_poller_if;

    logic [1:0] cpu_address;
    logic       SELECT_controller;
    logic       write_enable;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output cpu_address,
        output SELECT_controller,
        output write_enable,
        input  data_out,
        input  data_oe
    );

    modport slave (
        input  cpu_address,
        input  SELECT_controller,
        input  write_enable,
        output data_out,
        output data_oe
    );

endinterface

// File: rtl/controller_tick_gen_m.sv
// controller_tick_gen_m: free-running 0..CLK_DIV-1 divider for the pad timing.
//   clk    system clock
//   rst    synchronous active-high reset (count = 0)
//   en     count while asserted (poll in progress)
//   clr    restart the count at 0 (poll accepted); wins over en
//   tick_c combinational, high on the last count of each period while en
module controller_tick_gen_m #(
    parameter int unsigned CLK_DIV = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count;

    // Divider counter; wraps back to 0 after the tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == CW'(CLK_DIV - 1)) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick_c = en & (count == CW'(CLK_DIV - 1));

endmodule

// File: rtl/controller_poller.sv
// controller_poller: polls two NES-style shift-register pads and serves a
// tear-free snapshot of their buttons to the CPU.
//   clk_12_5875        system clock
//   rst                synchronous active-high reset
//   start_poll         one-cycle poll request (ignored while busy)
//   cpu                CPU bus (controller_poller_if.slave); read path is combinational
//   ctrl_latch         pad latch, active-high
//   ctrl_clk           pad shift clock
//   ctrl_data1/2       pad serial data, active-low
//   busy               poll in progress
// Optional build macro CONTROLLER_POLLER_EDGE_EN: keeps the previous snapshot per
// pad and exposes holding & ~prev (newly pressed) at cpu_address[1]=1.
module controller_poller
    import controller_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 64,
    parameter int unsigned NUM_BUTTONS = 8
) (
    input  logic                 clk_12_5875,
    input  logic                 rst,
    input  logic                 start_poll,
    controller_poller_if.slave   cpu,
    output logic                 ctrl_latch,
    output logic                 ctrl_clk,
    input  logic                 ctrl_data1,
    input  logic                 ctrl_data2,
    output logic                 busy
);

    localparam int unsigned IW  = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam int unsigned LCW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

    state_t                 state, state_next;
    logic [LCW-1:0]         latch_cnt, latch_cnt_next;
    logic [IW-1:0]          idx, idx_next;
    logic                   accept_c, sample_c, commit_c, tick_c;

    logic [NUM_BUTTONS-1:0] shift1, shift2;
    logic [NUM_BUTTONS-1:0] hold1, hold2;
    logic [NUM_BUTTONS-1:0] word_c;

    controller_tick_gen_m #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk_12_5875),
        .rst    (rst),
        .en     (state != ST_IDLE),
        .clr    (accept_c),
        .tick_c (tick_c)
    );

    // State register; pad and busy outputs are registered from the next state.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state      <= ST_IDLE;
            latch_cnt  <= '0;
            idx        <= '0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            latch_cnt  <= latch_cnt_next;
            idx        <= idx_next;
            ctrl_latch <= (state_next == ST_LATCH);
            ctrl_clk   <= (state_next == ST_CLK_HIGH);
            busy       <= (state_next != ST_IDLE);
        end
    end

    // Next-state logic; every phase advances only on a divider tick except COMMIT.
    always_comb begin
        state_next     = state;
        latch_cnt_next = latch_cnt;
        idx_next       = idx;
        accept_c       = 1'b0;
        sample_c       = 1'b0;
        commit_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_poll) begin
                    accept_c       = 1'b1;
                    latch_cnt_next = '0;
                    state_next     = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tick_c) begin
                    if (latch_cnt == LCW'(LATCH_TICKS - 1)) begin
                        idx_next   = '0;
                        state_next = ST_CLK_LOW;
                    end else begin
                        latch_cnt_next = latch_cnt + LCW'(1);
                    end
                end
            end
            ST_CLK_LOW: begin
                if (tick_c) begin
                    sample_c = 1'b1;
                    if (idx == IW'(NUM_BUTTONS - 1)) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_CLK_HIGH;
                    end
                end
            end
            ST_CLK_HIGH: begin
                if (tick_c) begin
                    idx_next   = idx + IW'(1);
                    state_next = ST_CLK_LOW;
                end
            end
            ST_COMMIT: begin
                commit_c   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef CONTROLLER_POLLER_EDGE_EN
    logic [NUM_BUTTONS-1:0] prev1, prev2;
`endif

    // Shift capture at the end of each low phase, snapshot copy at COMMIT.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            shift1 <= '0;
            shift2 <= '0;
            hold1  <= '0;
            hold2  <= '0;
`ifdef CONTROLLER_POLLER_EDGE_EN
            prev1  <= '0;
            prev2  <= '0;
`endif
        end else begin
            if (sample_c) begin
                shift1[idx] <= ~ctrl_data1;
                shift2[idx] <= ~ctrl_data2;
            end
            if (commit_c) begin
                hold1 <= shift1;
                hold2 <= shift2;
`ifdef CONTROLLER_POLLER_EDGE_EN
                prev1 <= hold1;
                prev2 <= hold2;
`endif
            end
        end
    end

    // CPU read mux; holding registers only change at COMMIT, so reads never tear.
    always_comb begin
        word_c = cpu.cpu_address[0] ? hold2 : hold1;
`ifdef CONTROLLER_POLLER_EDGE_EN
        if (cpu.cpu_address[1]) begin
            word_c = cpu.cpu_address[0] ? (hold2 & ~prev2) : (hold1 & ~prev1);
        end
`endif
    end

`ifndef CONTROLLER_POLLER_EDGE_EN
    // Address bit 1 is don't-care here: addresses 2/3 alias 0/1.
    logic unused_addr1;
    assign unused_addr1 = cpu.cpu_address[1];
`endif

    assign cpu.data_oe  = cpu.SELECT_controller & ~cpu.write_enable;
    assign cpu.data_out = cpu.data_oe ? 8'(word_c) : 8'h00;

endmodule
